mmio_uart_tx: RTL and testbench

- Memory-mapped responder on the CPU-to-memory request interface, decoded by the memory controller alongside on-chip RAM; gives the RV32IMA core a serial output channel.
- Accepts word-aligned load/store requests, buffers written bytes in a FIFO, and serialises them 8N1, LSB first, on a TX line at a programmable baud divisor.

---
 rtl/mmio_uart_tx_if.sv | 22 ++
 rtl/mmio_uart_tx.sv | 255 +++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU-to-memory request bundle for the UART TX responder.
// Single-wait-state load/store handshake with a one-cycle ready pulse.
`timescale 1ns/1ps
interface mmio_uart_tx_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] store;
  logic [3:0]  byte_en;
  logic        ready;
  logic [31:0] load;

  modport master (
    output ren, wen, addr, store, byte_en,
    input  ready, load
  );

  modport slave (
    input  ren, wen, addr, store, byte_en,
    output ready, load
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte TX FIFO.
// Optional parity frame bit is built when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;

  state_t        state;
  logic [15:0]   div;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [1:0]    par_cfg;

`ifdef UART_TX_PARITY_EN
  logic          par_en;
  logic          par_odd;
  logic          par_bit;
  logic          cfg_we;
`endif

  logic          req;
  logic          wr;
  logic          sel_tx;
  logic          sel_st;
  logic          sel_dv;
  logic          sel_rs;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          stall;
  logic          accept;
  logic          div_we;
  logic [15:0]   div_mix;
  logic [15:0]   div_nxt;
  logic [15:0]   div_m1;
  logic [3:0]    cnt4;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign full  = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign busy  = state != IDLE;
  assign cnt4  = 4'(count);

  // The cycle carrying ready still shows the old request; skip it.
  assign req    = (bus.ren | bus.wen) & ~bus.ready;
  assign wr     = bus.wen;
  assign sel_tx = bus.addr[3:2] == 2'd0;
  assign sel_st = bus.addr[3:2] == 2'd1;
  assign sel_dv = bus.addr[3:2] == 2'd2;
  assign sel_rs = bus.addr[3:2] == 2'd3;

  assign pop = ~empty &
    ((state == IDLE) |
     ((state == STOP) & (baud == 16'd0)));

  assign push_req = req & wr & sel_tx &
    bus.byte_en[0];
  // A full FIFO still accepts when an entry leaves this cycle.
  assign stall  = push_req & full & ~pop;
  assign accept = req & ~stall;
  assign push   = push_req & ~stall;

  assign div_we  = accept & wr & sel_dv;
  assign div_mix = {
    bus.byte_en[1] ? bus.store[15:8] : div[15:8],
    bus.byte_en[0] ? bus.store[7:0]  : div[7:0]
  };
  assign div_nxt = (div_mix == 16'd0) ?
    16'd1 : div_mix;
  assign div_m1  = div - 16'd1;

`ifdef UART_TX_PARITY_EN
  assign cfg_we  = accept & wr & sel_st &
    bus.byte_en[0];
  assign par_cfg = {par_odd, par_en};
`else
  assign par_cfg = 2'b00;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_st: rdata = {
        20'd0, cnt4, 2'b00, par_cfg,
        irq, busy, empty, full
      };
      sel_dv: rdata = {16'd0, div};
      sel_tx: rdata = '0;
      sel_rs: rdata = '0;
    endcase
  end

  assign unused_bits = ^{
    bus.addr[31:4], bus.addr[1:0],
    bus.store[31:16], bus.byte_en[3:2],
    BASE_ADDR
  };

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.store[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      irq       <= 1'b1;
      baud      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      div       <= DIV_RESET;
      bus.ready <= 1'b0;
      bus.load  <= '0;
`ifdef UART_TX_PARITY_EN
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      bus.ready <= accept;
      bus.load  <= (accept & ~wr) ? rdata : '0;
      irq       <= empty & ~busy;

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (div_we) div <= div_nxt;
`ifdef UART_TX_PARITY_EN
      if (cfg_we) begin
        par_en  <= bus.store[4];
        par_odd <= bus.store[5];
      end
`endif

      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rptr];
`ifdef UART_TX_PARITY_EN
            par_bit <= ^mem[rptr];
`endif
            state <= START;
            tx    <= 1'b0;
            baud  <= div_m1;
          end
        end
        START: begin
          if (baud == 16'd0) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= '0;
            baud    <= div_m1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud == 16'd0) begin
            baud <= div_m1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_en) begin
                state <= PARITY;
                tx    <= par_bit ^ par_odd;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud == 16'd0) begin
            state <= STOP;
            tx    <= 1'b1;
            baud  <= div_m1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud == 16'd0) begin
            // Next queued byte starts with no idle gap.
            if (pop) begin
              shift <= mem[rptr];
`ifdef UART_TX_PARITY_EN
              par_bit <= ^mem[rptr];
`endif
              state <= START;
              tx    <= 1'b0;
              baud  <= div_m1;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx.
// Define UART_TX_PARITY_EN to also exercise the parity frame.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus ();

  mmio_uart_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .tx  (tx),
    .irq (irq)
  );

  initial begin
    bus.ren     = 1'b0;
    bus.wen     = 1'b0;
    bus.addr    = '0;
    bus.store   = '0;
    bus.byte_en = '0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic xfer(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    output logic [31:0] rd,
    output int          lat
  );
    bus.ren = r; bus.wen = w;
    bus.addr = a; bus.store = d;
    bus.byte_en = be;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.ready !== 1'b1 && lat < 3000);
    rd = bus.load;
    bus.ren = 1'b0;
    bus.wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    while (irq !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: irq timeout got %b want 1", nm, irq);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0", bus.ready);
    end
    n_cmp++;
    if (bus.load !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_load: got %h want 0", bus.load);
    end
    n_cmp++;
    if (tx !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_tx: got %b want 1", tx);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_irq: got %b want 1", irq);
    end
    xfer(1'b1, 1'b0, A_ST, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0000_000A) begin
      n_bad++;
      $display("FAIL rst_status: got %h want 0000000a", rd);
    end
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL rst_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if (tx !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_tx_idle: got %b want 1", tx);
    end
  endtask

  task automatic test_frame();
    logic [31:0] rd;
    logic [9:0]  fr;
    int lat;
    int w;
    int bad;
    xfer(1'b0, 1'b1, A_DV, 32'd4, 4'h3, rd, lat);
    xfer(1'b1, 1'b0, A_DV, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'd4) begin
      n_bad++;
      $display("FAIL div_rd: got %h want 4", rd);
    end
    fr = {1'b1, 8'hA5, 1'b0};
    xfer(1'b0, 1'b1, A_TX, 32'hA5, 4'h1, rd, lat);
    w = 0;
    while (tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL frame_start: got %0d want 0", w);
    end
    bad = 0;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      if (tx !== fr[j/4]) begin
        bad++;
        if (bad == 1)
          $display("FAIL frame_a5 s%0d: got %b want %b",
                   j, tx, fr[j/4]);
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_stop_end: got %b want 0", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  vals [10];
    int lat;
    vals = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55,
             8'hAA, 8'h3C, 8'hC3, 8'h12, 8'hE7};
    xfer(1'b0, 1'b1, A_DV, 32'd2, 4'h3, rd, lat);
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          int exp_lat;
          exp_lat = (k == 9) ? 4 : 1;
          xfer(1'b0, 1'b1, A_TX, {24'h0, vals[k]},
               4'h1, rd, lat);
          n_cmp++;
          if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL b2b_lat%0d: got %0d want %0d",
                     k, lat, exp_lat);
          end
        end
      end
      begin
        int w = 0;
        int bad = 0;
        logic [9:0] fr;
        while (tx !== 1'b0 && w < 100) begin
          @(negedge clk);
          w++;
        end
        for (int f = 0; f < 10; f++) begin
          fr = {1'b1, vals[f], 1'b0};
          for (int j = 0; j < 20; j++) begin
            if (!(f == 0 && j == 0)) @(negedge clk);
            if (tx !== fr[j/2]) begin
              bad++;
              if (bad == 1)
                $display("FAIL b2b_f%0d s%0d: got %b want %b",
                         f, j, tx, fr[j/2]);
            end
          end
          n_cmp++;
          if (bad != 0) n_bad++;
          bad = 0;
        end
      end
    join
    wait_idle("b2b_idle");
  endtask

  task automatic test_midframe_reset();
    logic [31:0] rd;
    int lat;
    int w;
    int hi;
    xfer(1'b0, 1'b1, A_DV, 32'd4, 4'h3, rd, lat);
    xfer(1'b0, 1'b1, A_TX, 32'h35, 4'h1, rd, lat);
    w = 0;
    while (tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    xfer(1'b0, 1'b1, A_TX, 32'h99, 4'h1, rd, lat);
    repeat (15) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_bit3: got %b want 0", tx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (tx !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_tx: got %b want 1", tx);
    end
    hi = 1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (tx !== 1'b1) hi = 0;
    end
    n_cmp++;
    if (hi != 1) begin
      n_bad++;
      $display("FAIL mid_flush_tx: got %0d want 1", hi);
    end
    xfer(1'b1, 1'b0, A_ST, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0000_000A) begin
      n_bad++;
      $display("FAIL mid_status: got %h want 0000000a", rd);
    end
    xfer(1'b1, 1'b0, A_DV, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'd434) begin
      n_bad++;
      $display("FAIL mid_div: got %h want 1b2", rd);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    logic [9:0]  fr;
    int lat;
    int w;
    int bad;
    xfer(1'b0, 1'b1, A_DV, 32'd3, 4'h3, rd, lat);
    xfer(1'b1, 1'b1, A_TX, 32'h41, 4'h1, rd, lat);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL rw_load: got %h want 0", rd);
    end
    fr = {1'b1, 8'h41, 1'b0};
    w = 0;
    while (tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    bad = 0;
    for (int j = 1; j < 30; j++) begin
      @(negedge clk);
      if (tx !== fr[j/3]) begin
        bad++;
        if (bad == 1)
          $display("FAIL rw_frame s%0d: got %b want %b",
                   j, tx, fr[j/3]);
      end
    end
    n_cmp++;
    if (bad != 0 || w != 0) n_bad++;
    wait_idle("rw_idle");
    xfer(1'b0, 1'b1, A_DV, 32'h0, 4'h3, rd, lat);
    xfer(1'b1, 1'b0, A_DV, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_bad++;
      $display("FAIL div_zero: got %h want 1", rd);
    end
    xfer(1'b0, 1'b1, A_DV, 32'h1234, 4'h2, rd, lat);
    xfer(1'b1, 1'b0, BASE + 32'hA, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h1201) begin
      n_bad++;
      $display("FAIL div_be_alias: got %h want 1201", rd);
    end
    xfer(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h1201) begin
      n_bad++;
      $display("FAIL div_hi_addr: got %h want 1201", rd);
    end
    xfer(1'b0, 1'b1, A_RS, 32'hFFFF_FFFF, 4'hF, rd, lat);
    xfer(1'b1, 1'b0, A_RS, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL rsvd_rd: got %h want 0", rd);
    end
    xfer(1'b1, 1'b0, A_TX, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL txdata_rd: got %h want 0", rd);
    end
    xfer(1'b0, 1'b1, A_TX, 32'h77, 4'h2, rd, lat);
    xfer(1'b1, 1'b0, A_ST, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0000_000A) begin
      n_bad++;
      $display("FAIL no_be0_push: got %h want 0000000a", rd);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [31:0] rd;
    logic [10:0] fr;
    int lat;
    int w;
    int bad;
    xfer(1'b0, 1'b1, A_ST, 32'h10, 4'h1, rd, lat);
    xfer(1'b1, 1'b0, A_ST, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0000_001A) begin
      n_bad++;
      $display("FAIL par_status: got %h want 0000001a", rd);
    end
    xfer(1'b0, 1'b1, A_DV, 32'd2, 4'h3, rd, lat);
    xfer(1'b0, 1'b1, A_TX, 32'h07, 4'h1, rd, lat);
    fr = {1'b1, 1'b1, 8'h07, 1'b0};
    w = 0;
    while (tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    bad = 0;
    for (int j = 1; j < 22; j++) begin
      @(negedge clk);
      if (tx !== fr[j/2]) begin
        bad++;
        if (bad == 1)
          $display("FAIL par_frame s%0d: got %b want %b",
                   j, tx, fr[j/2]);
      end
    end
    n_cmp++;
    if (bad != 0 || w != 0) n_bad++;
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL par_irq0: got %b want 0", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL par_irq1: got %b want 1", irq);
    end
  endtask
`else
  task automatic test_cfg_ro();
    logic [31:0] rd;
    int lat;
    xfer(1'b0, 1'b1, A_ST, 32'h30, 4'h1, rd, lat);
    xfer(1'b1, 1'b0, A_ST, 32'h0, 4'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0000_000A) begin
      n_bad++;
      $display("FAIL cfg_ro: got %h want 0000000a", rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_midframe_reset();
    test_regs();
`ifdef UART_TX_PARITY_EN
    test_parity();
`else
    test_cfg_ro();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
